white_balance: RTL and testbench
================================

Name: white_balance

Overview:
Per-pixel white-balance gain stage for a Bayer-domain image signal processor. Each valid input sample carries a colour tag and an 8-bit value. The block multiplies the value by the gain for that colour and outputs a saturated 8-bit result two cycles later. Per-channel gains are loaded from the register/statistics side whenever valid_gain_i is asserted.

Parameters:
DATA_W, 8, pixel value width
GAIN_W, 16, gain width; unsigned fixed point U4.12, so 0x1000 = 1.0
FRAC_W, 12, fractional bits of the gain

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous reset, ACTIVE-HIGH despite the inherited name
valid_value_i  in  1  pixel sample valid this cycle
valid_gain_i  in  1  load K_R/K_G/K_B into the gain registers this cycle
color_i  in  2  colour tag: 00 R, 01 G, 10 B, 11 second G (Gb)
value_i  in  8  pixel value
K_R  in  16  red gain, U4.12
K_G  in  16  green gain, U4.12 (used for both 01 and 11)
K_B  in  16  blue gain, U4.12
valid_o  out  1  output sample valid
color_o  out  2  colour tag delayed with its sample
value_o  out  8  balanced pixel value

Behaviour:
- Reset is asynchronous and active-high on rst_n.
- Reset values: valid_o=0, color_o=0, value_o=0, internal pipeline valids=0.
- Gain registers reset to 0x1000 (unity).
- Gain load: on a clock edge with valid_gain_i=1, gR/gG/gB <= K_R/K_G/K_B.
- Gain bypass: a pixel accepted in the same cycle as valid_gain_i=1 uses the incoming K_* values, not the stale registers.
- Gain selection: color 00->R, 01->G, 11->G, 10->B.
- Stage 1, on a cycle with valid_value_i=1:
  - product <= value_i * gain, unsigned 24 bits.
  - Stage-1 colour and valid register are loaded.
- Stage 2:
  - res = (product + 0x800) >> 12, giving 13 bits without overflow.
  - value_o = 255 if res > 255, else res[7:0].
  - color_o is the delayed tag; valid_o is the delayed valid.
- Latency: exactly 2 cycles, valid_value_i at edge N -> valid_o high after edge N+2.
- Throughput: one sample per cycle, no back-pressure, no stall input.
- Idle cycles: when valid_value_i=0, the stage valid becomes 0 and the data registers hold their previous contents; value_o/color_o are don't-care while valid_o=0 but are stable.
- Gain changes mid-stream affect only samples accepted at or after the load edge; in-flight samples keep their product.
- Reset mid-stream: all in-flight samples are discarded, valid_o=0 immediately, and gains return to unity.
- Zero gain gives 0; gain 0xFFFF with value 255 saturates to 255.

Optional Feature:
WB_ROUND_EN
- Defined: round-to-nearest, adding 0x800 before the 12-bit shift as above.
- Undefined: truncation, res = product >> 12, with no adder in stage 2. Saturation is identical in both modes.

Decomposition:
- Shared package wb_pkg holds:
  - DATA_W, GAIN_W, FRAC_W;
  - colour enum COL_R=2'b00, COL_G=2'b01, COL_B=2'b10, COL_GB=2'b11;
  - UNITY_GAIN=16'h1000.
- One natural sub-module, wb_gain_mul: 8x16 multiply, round and saturate to 8 bits, combinational. The top level holds the gain registers, the selection mux and the pipeline registers.

Test Plan:
- Reset then color=00, value=0x80 with no gain load -> after 2 cycles valid_o=1, color_o=00, value_o=0x80 (unity).
- Gains K_R=0x0FF0, K_G=0xCCCC, K_B=0xF00F with valid_gain_i=1; stream R 0x0F, G 0xF0, B 0xCC back-to-back -> value_o 0x0F (0x0E without WB_ROUND_EN), then 0xFF, 0xFF (saturated) on consecutive cycles with colours 00,01,10.
- K_G=0x0800 (0.5), color=11, value=0xFF -> value_o=0x80 with rounding, 0x7F truncated; color_o=11.
- Gain change mid-stream: pixel 0x40 with K_R=0x2000 at edge N, K_R=0x1000 loaded at N+1 with pixel 0x40 -> outputs 0x80 then 0x40.
- Gap and valid: valid_value_i pattern 1,0,1 -> valid_o pattern 1,0,1 delayed by 2 cycles.
- Assert rst_n (high) while 2 samples are in flight -> valid_o=0 immediately, no stale sample after release, gains back to unity.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared types and constants for the white-balance gain stage.
package wb_pkg;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned GAIN_W = 16;
  localparam int unsigned FRAC_W = 12;
  localparam int unsigned PROD_W = DATA_W + GAIN_W;

  typedef enum logic [1:0] {
    COL_R  = 2'b00,
    COL_G  = 2'b01,
    COL_B  = 2'b10,
    COL_GB = 2'b11
  } color_e;

  // Gains are U4.12, so this is 1.0.
  localparam logic [GAIN_W-1:0] UNITY_GAIN = 16'h1000;

endpackage

// File: rtl/wb_gain_mul.sv
// Combinational gain arithmetic: 8x16 multiply, plus round/truncate and 8-bit saturation.
// The multiply and the scale/saturate halves are exposed separately so the caller can
// register the product between them.
// Build option: define WB_ROUND_EN for round-to-nearest; default is truncation.
module wb_gain_mul
  import wb_pkg::*;
(
  input  logic [DATA_W-1:0] value_i,
  input  logic [GAIN_W-1:0] gain_i,
  output logic [PROD_W-1:0] prod_o,
  input  logic [PROD_W-1:0] prod_i,
  output logic [DATA_W-1:0] value_o
);

  // 13-bit scaled result; cannot overflow even with the rounding adder.
  logic [PROD_W-FRAC_W:0] res;

  // Full-precision unsigned product.
  always_comb begin
    prod_o = PROD_W'(value_i) * PROD_W'(gain_i);
  end

`ifdef WB_ROUND_EN
  logic [PROD_W:0] sum;

  // Round to nearest: add half an LSB before dropping the fraction.
  always_comb begin
    sum = {1'b0, prod_i} + (PROD_W + 1)'(1 << (FRAC_W - 1));
    res = sum[PROD_W:FRAC_W];
  end
`else
  logic unused_frac;

  // Truncate: drop the fraction bits outright.
  always_comb begin
    res         = {1'b0, prod_i[PROD_W-1:FRAC_W]};
    unused_frac = ^prod_i[FRAC_W-1:0];
  end
`endif

  // Clamp anything above 255 to full scale.
  always_comb begin
    value_o = (|res[PROD_W-FRAC_W:DATA_W]) ? {DATA_W{1'b1}} : res[DATA_W-1:0];
  end

endmodule

// File: rtl/white_balance.sv
// Per-pixel white-balance gain stage: gain registers with same-cycle bypass, colour-based
// gain select, and a two-stage pipeline (product, then scaled/saturated output).
// Build option: WB_ROUND_EN selects rounding in wb_gain_mul.
// Note: rst_n is an active-high asynchronous reset despite its name.
module white_balance
  import wb_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              valid_value_i,
  input  logic              valid_gain_i,
  input  logic [1:0]        color_i,
  input  logic [DATA_W-1:0] value_i,
  input  logic [GAIN_W-1:0] K_R,
  input  logic [GAIN_W-1:0] K_G,
  input  logic [GAIN_W-1:0] K_B,
  output logic              valid_o,
  output logic [1:0]        color_o,
  output logic [DATA_W-1:0] value_o
);

  logic [GAIN_W-1:0] g_r_q, g_g_q, g_b_q;
  logic [GAIN_W-1:0] g_r, g_g, g_b, gain_sel;
  logic [PROD_W-1:0] prod_d, prod_q;
  logic [1:0]        col1_q;
  logic              vld1_q;
  logic [DATA_W-1:0] res_d;

  // Gain registers; reset to unity, reloaded whenever valid_gain_i is high.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      g_r_q <= UNITY_GAIN;
      g_g_q <= UNITY_GAIN;
      g_b_q <= UNITY_GAIN;
    end else if (valid_gain_i) begin
      g_r_q <= K_R;
      g_g_q <= K_G;
      g_b_q <= K_B;
    end
  end

  // A pixel arriving with a gain load uses the new gains, not the stale registers.
  always_comb begin
    g_r      = valid_gain_i ? K_R : g_r_q;
    g_g      = valid_gain_i ? K_G : g_g_q;
    g_b      = valid_gain_i ? K_B : g_b_q;
    gain_sel = g_g;
    unique case (color_e'(color_i))
      COL_R:         gain_sel = g_r;
      COL_G, COL_GB: gain_sel = g_g;
      COL_B:         gain_sel = g_b;
    endcase
  end

  wb_gain_mul u_mul (
    .value_i (value_i),
    .gain_i  (gain_sel),
    .prod_o  (prod_d),
    .prod_i  (prod_q),
    .value_o (res_d)
  );

  // Stage 1: capture the product; data holds across idle cycles.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      vld1_q <= 1'b0;
      col1_q <= 2'b00;
      prod_q <= '0;
    end else begin
      vld1_q <= valid_value_i;
      if (valid_value_i) begin
        col1_q <= color_i;
        prod_q <= prod_d;
      end
    end
  end

  // Stage 2: register the scaled, saturated result and its tag.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      valid_o <= 1'b0;
      color_o <= 2'b00;
      value_o <= '0;
    end else begin
      valid_o <= vld1_q;
      if (vld1_q) begin
        color_o <= col1_q;
        value_o <= res_d;
      end
    end
  end

endmodule

// File: tb/tb_white_balance.sv
// Directed bench for white_balance; expected values hand-computed for both rounding modes.
module tb_white_balance;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid_value_i;
  logic        valid_gain_i;
  logic [1:0]  color_i;
  logic [7:0]  value_i;
  logic [15:0] K_R, K_G, K_B;
  logic        valid_o;
  logic [1:0]  color_o;
  logic [7:0]  value_o;

  int n_total = 0;
  int n_pass  = 0;

`ifdef WB_ROUND_EN
  localparam logic [7:0] ExpR0F  = 8'h0F;  // 15*0x0FF0 = 0xEF10 -> 14.94
  localparam logic [7:0] ExpHalf = 8'h80;  // 255*0.5 = 127.5
  localparam logic [7:0] ExpGb   = 8'hCD;  // 16*0xCCCC/4096 = 204.8
`else
  localparam logic [7:0] ExpR0F  = 8'h0E;
  localparam logic [7:0] ExpHalf = 8'h7F;
  localparam logic [7:0] ExpGb   = 8'hCC;
`endif

  white_balance dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .valid_value_i (valid_value_i),
    .valid_gain_i  (valid_gain_i),
    .color_i       (color_i),
    .value_i       (value_i),
    .K_R           (K_R),
    .K_G           (K_G),
    .K_B           (K_B),
    .valid_o       (valid_o),
    .color_o       (color_o),
    .value_o       (value_o)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_total++;
    assert (obs === exp_v) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
  endtask

  initial begin
    rst_n = 1'b1; valid_value_i = 1'b0; valid_gain_i = 1'b0;
    color_i = 2'b00; value_i = 8'h00; K_R = 16'h0; K_G = 16'h0; K_B = 16'h0;
    tick(); tick();
    chk("rst_valid", valid_o, 1'b0);
    chk("rst_color", color_o, 2'b00);
    chk("rst_value", value_o, 8'h00);
    rst_n = 1'b0;
    tick();

    // Unity gain after reset
    color_i = 2'b00; value_i = 8'h80; valid_value_i = 1'b1;
    tick();
    valid_value_i = 1'b0;
    tick();
    chk("unity_valid", valid_o, 1'b1);
    chk("unity_color", color_o, 2'b00);
    chk("unity_value", value_o, 8'h80);

    // Gain load with bypass, back-to-back R/G/B stream
    K_R = 16'h0FF0; K_G = 16'hCCCC; K_B = 16'hF00F; valid_gain_i = 1'b1;
    color_i = 2'b00; value_i = 8'h0F; valid_value_i = 1'b1;
    tick();
    valid_gain_i = 1'b0; K_R = 16'h0; K_G = 16'h0; K_B = 16'h0;
    color_i = 2'b01; value_i = 8'hF0;
    tick();
    chk("rgb_r_value", value_o, ExpR0F);
    chk("rgb_r_color", color_o, 2'b00);
    color_i = 2'b10; value_i = 8'hCC;
    tick();
    chk("rgb_g_value", value_o, 8'hFF);
    chk("rgb_g_color", color_o, 2'b01);
    chk("rgb_g_valid", valid_o, 1'b1);
    valid_value_i = 1'b0;
    tick();
    chk("rgb_b_value", value_o, 8'hFF);
    chk("rgb_b_color", color_o, 2'b10);

    // Registered green gain used for Gb while K_* inputs are garbage
    color_i = 2'b11; value_i = 8'h10; valid_value_i = 1'b1;
    tick();
    valid_value_i = 1'b0;
    tick();
    chk("hold_gb_value", value_o, ExpGb);

    // Half gain on Gb
    K_R = 16'h1000; K_G = 16'h0800; K_B = 16'h1000; valid_gain_i = 1'b1;
    color_i = 2'b11; value_i = 8'hFF; valid_value_i = 1'b1;
    tick();
    valid_gain_i = 1'b0; valid_value_i = 1'b0;
    tick();
    chk("half_value", value_o, ExpHalf);
    chk("half_color", color_o, 2'b11);

    // Gain change mid-stream
    K_R = 16'h2000; K_G = 16'h1000; valid_gain_i = 1'b1;
    color_i = 2'b00; value_i = 8'h40; valid_value_i = 1'b1;
    tick();
    K_R = 16'h1000;
    tick();
    chk("mid_first", value_o, 8'h80);
    valid_gain_i = 1'b0; valid_value_i = 1'b0;
    tick();
    chk("mid_second", value_o, 8'h40);

    // Zero gain and maximum gain
    K_R = 16'h0000; K_G = 16'hFFFF; K_B = 16'h1000; valid_gain_i = 1'b1;
    color_i = 2'b00; value_i = 8'hFF; valid_value_i = 1'b1;
    tick();
    valid_gain_i = 1'b0; color_i = 2'b01;
    tick();
    chk("zero_gain", value_o, 8'h00);
    valid_value_i = 1'b0;
    tick();
    chk("max_gain_sat", value_o, 8'hFF);

    // Gap pattern 1,0,1 at unity
    K_R = 16'h1000; K_G = 16'h1000; K_B = 16'h1000; valid_gain_i = 1'b1;
    tick();
    valid_gain_i = 1'b0;
    color_i = 2'b10; value_i = 8'h33; valid_value_i = 1'b1;
    tick();
    valid_value_i = 1'b0;
    tick();
    chk("gap_v0", valid_o, 1'b1);
    chk("gap_d0", value_o, 8'h33);
    color_i = 2'b00; value_i = 8'h55; valid_value_i = 1'b1;
    tick();
    chk("gap_v1", valid_o, 1'b0);
    chk("gap_hold", value_o, 8'h33);
    valid_value_i = 1'b0;
    tick();
    chk("gap_v2", valid_o, 1'b1);
    chk("gap_d2", value_o, 8'h55);
    chk("gap_c2", color_o, 2'b00);
    tick();
    chk("gap_v3", valid_o, 1'b0);

    // Reset with two samples in flight
    K_R = 16'h3000; valid_gain_i = 1'b1;
    color_i = 2'b00; value_i = 8'h10; valid_value_i = 1'b1;
    tick();
    valid_gain_i = 1'b0; value_i = 8'h20;
    tick();
    chk("pre_rst_valid", valid_o, 1'b1);
    rst_n = 1'b1;
    #1;
    chk("rst_async_valid", valid_o, 1'b0);
    chk("rst_async_value", value_o, 8'h00);
    valid_value_i = 1'b0;
    tick();
    rst_n = 1'b0;
    tick();
    chk("post_rst_v0", valid_o, 1'b0);
    tick();
    chk("post_rst_v1", valid_o, 1'b0);
    color_i = 2'b00; value_i = 8'h40; valid_value_i = 1'b1;
    tick();
    valid_value_i = 1'b0;
    tick();
    chk("post_rst_unity", value_o, 8'h40);
    chk("post_rst_valid", valid_o, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
